// File: rtl/rgmii_link_pkg.sv
// rtl/rgmii_link_pkg.sv - shared speed encodings, MDIO frame constants and FSM states
package rgmii_link_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  localparam logic [1:0] MDIO_ST      = 2'b01;
  localparam logic [1:0] MDIO_OP_READ = 2'b10;
  localparam int PREAMBLE_LEN = 32;
  localparam int CMD_LEN      = 14;
  localparam int TA_LEN       = 2;
  localparam int FRAME_LEN    = 64;

  typedef enum logic [2:0] {IDLE, PRE, CMD, TA, RD, UPD, HOLD} state_t;

endpackage

// File: rtl/mdio_read_master.sv
// rtl/mdio_read_master.sv - MDC divider, 64-bit MDIO read frame shifter and pad control
module mdio_read_master
  import rgmii_link_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic        mdio_i,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        busy,
  output logic        done,
  output logic [15:0] data
);

  localparam int DW = $clog2(CLK_DIV);

  state_t         state, state_nx;
  logic [DW-1:0]  div_cnt;
  logic [6:0]     bit_cnt;
  logic [6:0]     nxt_bit;
  logic [13:0]    cmd;
  logic [15:0]    rx;
  logic           tick, rise, fall;

  assign busy    = (state != IDLE);
  assign tick    = busy && (div_cnt == DW'(CLK_DIV - 1));
  assign rise    = tick && !mdc;
  assign fall    = tick && mdc;
  assign nxt_bit = bit_cnt + 7'd1;
  // The frame ends on the 64th falling edge, so the last sampled bit is already in rx.
  assign done    = fall && (bit_cnt == 7'(FRAME_LEN - 1));
  assign data    = rx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = PRE;
      PRE:  if (fall && nxt_bit == 7'(PREAMBLE_LEN)) state_nx = CMD;
      CMD:  if (fall && nxt_bit == 7'(PREAMBLE_LEN + CMD_LEN)) state_nx = TA;
      TA:   if (fall && nxt_bit == 7'(PREAMBLE_LEN + CMD_LEN + TA_LEN)) state_nx = RD;
      RD:   if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      mdc     <= 1'b0;
      mdio_o  <= 1'b1;
      mdio_t  <= 1'b1;
      cmd     <= '0;
      rx      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        mdc     <= 1'b0;
        // Frame start acts as the first bit boundary: preamble drive begins here.
        if (start) begin
          cmd    <= {MDIO_ST, MDIO_OP_READ, phy_addr, reg_addr};
          mdio_o <= 1'b1;
          mdio_t <= 1'b0;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) mdc <= ~mdc;
        if (rise && state == RD) rx <= {rx[14:0], mdio_i};
        if (fall) begin
          bit_cnt <= nxt_bit;
          if (state_nx == CMD) begin
            mdio_o <= cmd[13];
            cmd    <= {cmd[12:0], 1'b0};
          end else if (state_nx != PRE) begin
            mdio_o <= 1'b1;
            mdio_t <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rgmii_link_ctrl.sv
// rtl/rgmii_link_ctrl.sv - PHY status poller driving RGMII speed and link reset
// Optional link_irq output when LINK_CHANGE_IRQ_EN is defined.
module rgmii_link_ctrl
  import rgmii_link_pkg::*;
#(
  parameter int         CLK_DIV       = 25,
  parameter int         POLL_INTERVAL = 1250000,
  parameter logic [4:0] PHY_ADDR      = 5'd0,
  parameter logic [4:0] STATUS_REG    = 5'h11,
  parameter int         SPEED_MSB     = 15,
  parameter int         LINK_BIT      = 10,
  parameter int         RST_HOLD      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        poll_now,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic [1:0]  speed,
  output logic        link_up,
  output logic        link_rst,
  output logic [15:0] status,
`ifdef LINK_CHANGE_IRQ_EN
  output logic        link_irq,
`endif
  output logic        busy
);

  localparam int TW = $clog2(POLL_INTERVAL + 1);
  localparam int HW = $clog2(RST_HOLD + 1);

  // PRE here covers the whole frame; the master tracks PRE/CMD/TA/RD itself.
  state_t          state, state_nx;
  logic [TW-1:0]   poll_timer;
  logic [HW-1:0]   hold_cnt;
  logic            first_poll;
  logic            go, start, frame_done, speed_chg;
  logic [15:0]     rd_data;
  logic [1:0]      dec_speed;

  assign dec_speed = rd_data[SPEED_MSB -: 2];
  assign speed_chg = rd_data[LINK_BIT] && (dec_speed != 2'b11) && (dec_speed != speed);
  assign go        = enable && (poll_timer == TW'(POLL_INTERVAL - 1) || poll_now || first_poll);
  assign start     = (state == IDLE) && go;
  assign link_rst  = (state == HOLD);

`ifdef LINK_CHANGE_IRQ_EN
  assign link_irq = (state == UPD) && ((rd_data[LINK_BIT] != link_up) || speed_chg);
`endif

  mdio_read_master #(.CLK_DIV(CLK_DIV)) u_mdio (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .phy_addr (PHY_ADDR),
    .reg_addr (STATUS_REG),
    .mdio_i   (mdio_i),
    .mdc      (mdc),
    .mdio_o   (mdio_o),
    .mdio_t   (mdio_t),
    .busy     (busy),
    .done     (frame_done),
    .data     (rd_data)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (go) state_nx = PRE;
      PRE:  if (frame_done) state_nx = UPD;
      UPD:  state_nx = speed_chg ? HOLD : IDLE;
      HOLD: if (hold_cnt == HW'(RST_HOLD - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      poll_timer <= '0;
      hold_cnt   <= '0;
      first_poll <= 1'b1;
      speed      <= SPEED_1000;
      link_up    <= 1'b0;
      status     <= '0;
    end else begin
      state <= state_nx;
      if (state != IDLE || state_nx != IDLE) poll_timer <= '0;
      else if (enable) poll_timer <= poll_timer + TW'(1);
      if (state == IDLE && state_nx == PRE) first_poll <= 1'b0;
      hold_cnt <= (state == HOLD) ? hold_cnt + HW'(1) : '0;
      if (state == UPD) begin
        status  <= rd_data;
        link_up <= rd_data[LINK_BIT];
        if (speed_chg) speed <= dec_speed;
      end
    end
  end

endmodule

// File: doc/rgmii_link_ctrl.md
Name: rgmii_link_ctrl

Overview:
Polls the external RGMII PHY over MDIO, decodes link and speed from the PHY-specific status register, and drives the `speed[1:0]` input of the RGMII PHY interface. On a speed change it requests a reset of the RGMII/MAC path, so the TX clock divider and the GMII clock-enable restart cleanly. It sits between the PHY's management pins and the RGMII interface and MAC.

Parameters:
CLK_DIV, 25, clk cycles per MDC half-period (125 MHz / 50 = 2.5 MHz MDC); legal range 2..255
POLL_INTERVAL, 1250000, clk cycles from the end of one MDIO read to the start of the next (10 ms)
PHY_ADDR, 5'd0, MDIO PHY address
STATUS_REG, 5'h11, PHY register address that is read
SPEED_MSB, 15, status bit position of speed[1]; speed[0] is at SPEED_MSB-1
LINK_BIT, 10, status bit position of the real-time link flag
RST_HOLD, 16, clk cycles that link_rst is held high after a speed change

Ports:
clk  in  1  single clock, shared with the RGMII TX clock domain
rst  in  1  synchronous, active-high reset
enable  in  1  polling allowed while high
poll_now  in  1  single-cycle pulse that forces an immediate poll
mdc  out  1  MDIO management clock
mdio_i  in  1  MDIO data from the pad
mdio_o  out  1  MDIO data to the pad
mdio_t  out  1  pad tristate control; 1 = released
speed  out  2  00 = 10M, 01 = 100M, 10 = 1000M; connects to the RGMII interface speed input
link_up  out  1  link flag from the last successful read
link_rst  out  1  reset request to the RGMII interface and MAC
status  out  16  raw value of the last read
busy  out  1  high while an MDIO frame is in progress

Behaviour:
- Reset values: mdc=0, mdio_o=1, mdio_t=1, speed=2'b10, link_up=0, link_rst=0, status=16'h0, busy=0; poll timer=0; FSM in IDLE.
- FSM states: IDLE, PRE, CMD, TA, RD, UPD, HOLD.
- IDLE:
  - Go to PRE when enable=1 and (poll timer reaches POLL_INTERVAL-1, or poll_now=1, or this is the first cycle after reset).
  - The timer counts only in IDLE with enable=1. It clears on leaving IDLE.
  - poll_now received outside IDLE is ignored.
- MDC generation:
  - A divider toggles mdc every CLK_DIV clk cycles while the FSM is in PRE, CMD, TA or RD. mdc is held 0 in all other states.
  - mdio_o and mdio_t change only on the clk cycle on which mdc falls.
  - mdio_i is sampled on the clk cycle on which mdc rises.
- Frame bit counts (one bit per MDC period, 64 MDC periods per frame):
  - PRE: 32 bits of 1.
  - CMD: 14 bits, sent MSB first: ST=01, OP=10 (read), PHY_ADDR, STATUS_REG.
  - TA: 2 bits with mdio_t=1.
  - RD: 16 bits shifted in MSB first.
- busy=1 from entry to PRE until exit from RD.
- UPD (one cycle):
  - status <= shifted data; link_up <= data[LINK_BIT].
  - If link=1, the decoded speed is not 2'b11, and the decoded speed differs from the current speed: update speed in this cycle and go to HOLD.
  - Otherwise go to IDLE.
  - Decoded speed 2'b11 (reserved) leaves speed unchanged.
  - Link down leaves speed unchanged.
- HOLD: link_rst=1 for exactly RST_HOLD cycles, starting the cycle after UPD, then return to IDLE.
- Pass-through fields: the controller never depends on the PHY turnaround bit, and any read value is accepted as-is (an absent PHY returns 16'hFFFF).
- enable falling mid-frame: the current frame and any HOLD period complete; the block then stays in IDLE.
- rst mid-frame: the frame aborts on the next edge and every output takes its reset value (speed returns to 2'b10).

Optional Feature:
LINK_CHANGE_IRQ_EN
- When defined: adds output `link_irq` (1 bit), reset value 0. It pulses high for one cycle in UPD when link_up changes value or speed is updated.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package rgmii_link_pkg holds:
  - speed encodings SPEED_10=2'b00, SPEED_100=2'b01, SPEED_1000=2'b10;
  - MDIO constants MDIO_ST=2'b01, MDIO_OP_READ=2'b10, PREAMBLE_LEN=32, FRAME_LEN=64;
  - the FSM state enum.
- Sub-module mdio_read_master owns the MDC divider, frame shifter and pad control. Its interface is start/addr/reg in, done/data out.
- rgmii_link_ctrl contains the poll timer, decode, UPD/HOLD logic and the speed register.

Test Plan:
- After reset with enable=1, PHY model returns 16'hAC00 (link=1, speed=10): frame starts within 1 cycle; mdc period = 50 clk; exactly 32 preamble ones and command bits 0110_00000_10001; TA released; then speed stays 2'b10, link_up=1, link_rst never asserted.
- PHY returns 16'h6400 (speed=01, link=1) while speed=10: speed becomes 2'b01 in UPD; link_rst high for exactly 16 cycles starting the following cycle.
- PHY returns 16'h2000 (link=0): link_up=0, speed unchanged, no link_rst. With LINK_CHANGE_IRQ_EN defined, link_irq pulses once.
- PHY returns 16'hC400 (reserved speed 11): speed unchanged, status=16'hC400.
- Poll timing, with POLL_INTERVAL=100: the next frame starts 100 cycles after UPD; a poll_now pulse while busy is ignored; a poll_now pulse in IDLE starts the frame on the next cycle.
- Assert rst at bit 40 of a frame: on the next cycle mdc=0, mdio_t=1, speed=2'b10, busy=0; a fresh frame starts once rst is released.
